// File: rtl/harvard_pkg.sv
// Shared types and constants for the Harvard sequencer.
// States, opcodes, ALU modes and the control word.
package harvard_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [5:0] OPC_LOAD  = 6'b100000;
  localparam logic [5:0] OPC_STORE = 6'b100001;
  localparam logic [5:0] OPC_NOP   = 6'b110000;
  localparam logic [5:0] OPC_PRINT = 6'b110001;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_IMM = 2'b01;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_FUNC = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic       mread;
    logic       mwrite;
    logic       alusrc;
    logic       rdt;
    logic       mtr;
    logic       rwrite;
    logic       regprint;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Keep the level controls, drop the one-cycle write strobes.
  function automatic ctrl_t level_only(ctrl_t c);
    ctrl_t r;
    r = c;
    r.rwrite   = 1'b0;
    r.mwrite   = 1'b0;
    r.regprint = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/harvard_decode.sv
// Opcode decoder for the Harvard sequencer.
// Pure combinational: opcode to control word, legal, is_halt.
module harvard_decode
  import harvard_pkg::*;
(
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              legal,
  output logic              is_halt
);

  ctrl_t c;

  // Map each opcode class onto its datapath controls.
  always_comb begin
    c       = '0;
    legal   = 1'b1;
    is_halt = 1'b0;
    unique case (1'b1)
      opcode[5:4] == CLS_ALU: begin
        c.rdt    = 1'b1;
        c.op     = OP_FUNC;
        c.rwrite = 1'b1;
      end
      opcode[5:4] == CLS_IMM: begin
        c.alusrc = 1'b1;
        c.op     = OP_ADD;
        c.rwrite = 1'b1;
      end
      opcode == OPC_LOAD: begin
        c.mread  = 1'b1;
        c.mtr    = 1'b1;
        c.rwrite = 1'b1;
      end
      opcode == OPC_STORE: c.mwrite   = 1'b1;
      opcode == OPC_NOP:   c        = '0;
      opcode == OPC_PRINT: c.regprint = 1'b1;
      opcode == OPC_HALT:  is_halt  = 1'b1;
      default:             legal    = 1'b0;
    endcase
  end

  assign ctrl_word = c;

endmodule

// File: rtl/harvard_ctrl.sv
// Four-cycle fetch/latch/exec/wb sequencer.
// Controls are registered, loaded one cycle ahead.
module harvard_ctrl
  import harvard_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr,
  output logic [1:0]      op,
  output logic            mread,
  output logic            mwrite,
  output logic            alusrc,
  output logic            rdt,
  output logic            mtr,
  output logic            rwrite,
  output logic            regprint,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  state_t            state;
  ctrl_t             ctrl_q;
  ctrl_t             dec;
  logic [CTRL_W-1:0] dec_word;
  logic [5:0]        dec_opc;
  logic              dec_legal;
  logic              dec_halt;

  // In LATCH the incoming word is decoded so EXEC controls
  // and the halt decision are ready at the next edge.
  assign dec_opc = (state == S_LATCH) ? imem_data[31:26]
                                      : instr[31:26];

  harvard_decode u_decode (
    .opcode    (dec_opc),
    .ctrl_word (dec_word),
    .legal     (dec_legal),
    .is_halt   (dec_halt)
  );

  assign dec = ctrl_t'(dec_word);

  // Sequencer with registered strobes and status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      instr   <= '0;
      illegal <= 1'b0;
      imem_rd <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      imem_rd <= 1'b0;
      ctrl_q  <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            imem_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          instr <= imem_data;
          pc    <= pc + 1'b1;
          if (!dec_legal)
            illegal <= 1'b1;
          if (!dec_legal || dec_halt) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state  <= S_EXEC;
            ctrl_q <= level_only(dec);
          end
        end
        S_EXEC: begin
          state  <= S_WB;
          ctrl_q <= dec;
        end
        S_WB: begin
          state   <= S_FETCH;
          imem_rd <= 1'b1;
        end
        S_HALTED: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= START_PC;
            illegal <= 1'b0;
            imem_rd <= 1'b1;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc;
  assign op        = ctrl_q.op;
  assign mread     = ctrl_q.mread;
  assign mwrite    = ctrl_q.mwrite;
  assign alusrc    = ctrl_q.alusrc;
  assign rdt       = ctrl_q.rdt;
  assign mtr       = ctrl_q.mtr;
  assign rwrite    = ctrl_q.rwrite;
  assign regprint  = ctrl_q.regprint;

endmodule

// File: tb/tb_harvard_ctrl.sv
// Bench for harvard_ctrl: opcode vector table plus
// sequences for store/print, restart, reset and PC wrap.
module tb_harvard_ctrl;
  import harvard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [1:0]  op;
  logic        mread, mwrite, alusrc, rdt, mtr;
  logic        rwrite, regprint;
  logic [7:0]  pc;
  logic        busy, halted, illegal;

  logic        w_start = 1'b0;
  logic        w_rd;
  logic [1:0]  w_addr;
  logic [31:0] w_data = '0;
  logic [31:0] w_instr;
  logic [1:0]  w_op;
  logic        w_mread, w_mwrite, w_alusrc, w_rdt, w_mtr;
  logic        w_rwrite, w_regprint;
  logic [1:0]  w_pc;
  logic        w_busy, w_halted, w_illegal;

  harvard_ctrl #(.PC_W(8), .START_PC(8'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr(instr), .op(op),
    .mread(mread), .mwrite(mwrite), .alusrc(alusrc),
    .rdt(rdt), .mtr(mtr), .rwrite(rwrite),
    .regprint(regprint), .pc(pc), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  harvard_ctrl #(.PC_W(2), .START_PC(2'd0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start),
    .imem_rd(w_rd), .imem_addr(w_addr),
    .imem_data(w_data), .instr(w_instr), .op(w_op),
    .mread(w_mread), .mwrite(w_mwrite), .alusrc(w_alusrc),
    .rdt(w_rdt), .mtr(w_mtr), .rwrite(w_rwrite),
    .regprint(w_regprint), .pc(w_pc), .busy(w_busy),
    .halted(w_halted), .illegal(w_illegal)
  );

  logic [31:0] rom [256];

  // ROM models: data valid the cycle after the read strobe.
  always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];
  always @(posedge clk) if (w_rd) w_data <= {OPC_NOP, 26'h0};

  int total  = 0;
  int passed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    w_start = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // {imem_rd,busy,halted,illegal,op,mread,mwrite,
  //  alusrc,rdt,mtr,rwrite,regprint}
  function automatic logic [12:0] outs();
    return {imem_rd, busy, halted, illegal, op, mread, mwrite,
            alusrc, rdt, mtr, rwrite, regprint};
  endfunction

  typedef struct {
    logic [5:0] opc;
    logic [1:0] op;
    logic [3:0] lvl;   // mread, mtr, alusrc, rdt
    logic [2:0] wstb;  // rwrite, mwrite, regprint
    logic       stop;
    logic       ill;
  } vec_t;

  // Expected outputs in cycle c after start, program {opc, HALT}.
  function automatic logic [12:0] exp_out(vec_t v, int c);
    logic rd, bz, hl, il;
    logic [1:0] o;
    logic [3:0] lv;
    logic [2:0] ws;
    rd = 0; bz = 0; hl = 0; il = 0; o = 0; lv = 0; ws = 0;
    if (v.stop) begin
      if (c == 1) begin rd = 1; bz = 1; end
      else if (c == 2) bz = 1;
      else begin hl = 1; il = v.ill; end
    end else begin
      case (c)
        1, 5: begin rd = 1; bz = 1; end
        2, 6: bz = 1;
        3: begin bz = 1; o = v.op; lv = v.lvl; end
        4: begin bz = 1; o = v.op; lv = v.lvl; ws = v.wstb; end
        default: hl = 1;
      endcase
    end
    return {rd, bz, hl, il, o, lv[3], ws[1],
            lv[1], lv[0], lv[2], ws[2], ws[0]};
  endfunction

  task automatic run_vec(vec_t v);
    do_reset();
    rom[0] = {v.opc, 26'h15A5A5A};
    rom[1] = {OPC_HALT, 26'h0};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("vec%b_c%0d", v.opc, c), 32'(outs()),
          32'(exp_out(v, c)));
      if (c < 8) step();
    end
    chk($sformatf("vec%b_pc", v.opc), 32'(pc),
        v.stop ? 32'd1 : 32'd2);
    chk($sformatf("vec%b_instr", v.opc), instr,
        v.stop ? rom[0] : rom[1]);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{6'b000001, 2'b10, 4'b0001, 3'b100, 0, 0};
    vecs[1] = '{6'b010011, 2'b00, 4'b0010, 3'b100, 0, 0};
    vecs[2] = '{6'b100000, 2'b00, 4'b1100, 3'b100, 0, 0};
    vecs[3] = '{6'b100001, 2'b00, 4'b0000, 3'b010, 0, 0};
    vecs[4] = '{6'b110000, 2'b00, 4'b0000, 3'b000, 0, 0};
    vecs[5] = '{6'b110001, 2'b00, 4'b0000, 3'b001, 0, 0};
    vecs[6] = '{6'b101010, 2'b00, 4'b0000, 3'b000, 1, 1};
    vecs[7] = '{6'b111111, 2'b00, 4'b0000, 3'b000, 1, 0};
    vecs[8] = '{6'b110010, 2'b00, 4'b0000, 3'b000, 1, 1};
    for (int i = 0; i < 256; i++) rom[i] = '0;

    do_reset();
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_instr", instr, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // STORE, PRINT, HALT with start held high while busy.
    do_reset();
    rom[0] = {OPC_STORE, 26'h0};
    rom[1] = {OPC_PRINT, 26'h0};
    rom[2] = {OPC_HALT, 26'h0};
    start = 1'b1;
    step();
    for (int c = 1; c <= 11; c++) begin
      logic [4:0] e;
      start = (c >= 2 && c <= 7);
      e = '0;
      e[4] = (c == 1 || c == 5 || c == 9);
      e[3] = (c == 4);
      e[2] = (c == 8);
      e[0] = (c == 11);
      chk($sformatf("stpr_c%0d", c),
          32'({imem_rd, mwrite, regprint, rwrite, halted}),
          32'(e));
      if (c < 11) step();
    end
    start = 1'b0;
    chk("stpr_pc", 32'(pc), 32'd3);

    // Illegal opcode, then restart from HALTED.
    do_reset();
    rom[0] = {6'b101010, 26'h0};
    rom[1] = {OPC_HALT, 26'h0};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("ill_state", 32'({halted, illegal, busy, rwrite, mwrite}),
        32'b11000);
    rom[0] = {OPC_NOP, 26'h0};
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_outs", 32'(outs()), 32'(13'b1100000000000));
    chk("restart_pc", 32'(pc), 32'd0);
    for (int c = 2; c <= 7; c++) step();
    chk("restart_halt", 32'({halted, illegal}), 32'b10);
    chk("restart_pc2", 32'(pc), 32'd2);

    // Reset asserted during WB of an ALU op, start pulsed too.
    do_reset();
    rom[0] = {6'b000001, 26'h0};
    rom[1] = {OPC_HALT, 26'h0};
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("rstwb_rwrite", 32'(rwrite), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    step();
    chk("rstwb_outs", 32'(outs()), 32'd0);
    chk("rstwb_pc", 32'(pc), 32'd0);
    chk("rstwb_instr", instr, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk("rstwb_idle", 32'(outs()), 32'd0);

    // PC wrap on a 2-bit program counter, all NOPs.
    do_reset();
    w_start = 1'b1;
    step();
    w_start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (c % 4 == 1)
        chk($sformatf("wrap_c%0d", c), 32'({w_rd, w_addr}),
            32'({1'b1, 2'((c / 4) % 4)}));
      if (c < 17) step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/harvard_ctrl.md
# harvard_ctrl

Multi-cycle sequencer for the 8-bit Harvard processor datapath. Fetches 32-bit instructions from the instruction ROM through a program counter, holds each in an instruction register that drives the datapath `instr` bus, and decodes the opcode. Issues the datapath control strobes (`op`, `mread`, `mwrite`, `alusrc`, `rdt`, `mtr`, `rwrite`, `regprint`) in a fixed four-cycle schedule. Stops on HALT or on an illegal opcode.

## Interface

Parameters:
- `PC_W`, 8: program counter and instruction ROM address width.
- `START_PC`, 0: PC value loaded by reset and by restart.

Ports:
- `clk` in 1: rising-edge clock. All state changes on this edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin execution from IDLE or HALTED. Ignored while busy.
- `imem_rd` out 1: instruction ROM read strobe.
- `imem_addr` out PC_W: ROM address. Equals `pc`.
- `imem_data` in 32: ROM data, valid exactly one cycle after `imem_rd`.
- `instr` out 32: instruction register, connected to the datapath.
- `op` out 2: ALU mode.
- `mread`, `mwrite`, `alusrc`, `rdt`, `mtr`, `rwrite`, `regprint` out 1 each: datapath controls.
- `pc` out PC_W: current program counter.
- `busy` out 1: high in FETCH, LATCH, EXEC and WB.
- `halted` out 1: high in HALTED.
- `illegal` out 1: sticky. Set when an undefined opcode is decoded.

## Operation

- **Decode** uses opcode = `instr[31:26]`.
  - 00xxxx, ALU R-type: `rdt`=1, `op`=2'b10, `rwrite` pulsed.
  - 01xxxx, load-immediate: `alusrc`=1, `op`=2'b00, `rwrite` pulsed.
  - 100000, LOAD: `mread`=1, `mtr`=1, `rwrite` pulsed.
  - 100001, STORE: `mwrite` pulsed.
  - 110000, NOP: no controls asserted.
  - 110001, PRINT: `regprint` pulsed.
  - 111111, HALT.
  - Any other opcode is illegal: `illegal` is set and the FSM goes to HALTED.
- **FSM states**
  - IDLE: on `start`, go to FETCH.
  - FETCH: `imem_rd`=1. Next state LATCH.
  - LATCH: `instr` <= `imem_data`; `pc` <= `pc`+1, wrapping modulo 2^PC_W. Next state EXEC, or HALTED if the new opcode is HALT or illegal.
  - EXEC: level controls (`rdt`, `alusrc`, `op`, `mread`, `mtr`) asserted so datapath reads and the ALU settle. Next state WB.
  - WB: level controls held; write strobes (`rwrite`, `mwrite`, `regprint`) high for this one cycle only. Next state FETCH.
  - HALTED: all controls 0, `halted`=1. On `start`: `pc` <= START_PC, `illegal` cleared, go to FETCH.
- The HALTED decision is made combinationally on `imem_data` in LATCH, so EXEC for HALT or illegal opcodes is never entered.
- `instr` holds its value from LATCH until the next LATCH, so it is stable throughout EXEC and WB.
- `start` is ignored in FETCH, LATCH, EXEC and WB.
- PC wrap: an instruction at 2^PC_W−1 is followed by a fetch from 0. No flag is raised.

## Timing

- Reset: the next edge with `rst_n`=0 forces IDLE.
  - `pc`=START_PC, `instr`=0, `illegal`=0.
  - All control outputs, `imem_rd`, `busy` and `halted` are 0.
  - Reset mid-instruction aborts it. A write strobe asserted in that cycle still lands, and is deasserted the following cycle.
- Throughput: 4 cycles per instruction (FETCH, LATCH, EXEC, WB).
- Start latency: `start` sampled in IDLE, then `imem_rd` is high in the next cycle.
- HALT: `halted` rises 2 cycles after the FETCH of the HALT instruction. `pc` then points past the HALT.
- All outputs are registered or decoded from the state and instruction register only. There is no combinational path from `start` to any output.

## Structure

- Shared package `harvard_pkg` holds:
  - State enum: IDLE, FETCH, LATCH, EXEC, WB, HALTED.
  - Opcode constants: OPC_LOAD, OPC_STORE, OPC_NOP, OPC_PRINT, OPC_HALT.
  - Class prefixes: 2'b00 ALU, 2'b01 IMM.
  - `op` encodings.
- One sub-module, `harvard_decode`: combinational opcode to {control word, legal, is_halt}. The FSM gates its write strobes by state.

## Test plan

- Reset then `start`, with ROM[0] = ALU opcode 000001, ROM[1] = HALT → `rwrite` high only in cycle 4 after start. `halted`=1 at cycle 7. `pc`=2, `illegal`=0.
- ROM[0] = 100000 (LOAD) → `mread`=`mtr`=1 in EXEC and WB; `rwrite` a one-cycle pulse in WB; `mwrite`=0 throughout.
- ROM[0] = 100001 (STORE), ROM[1] = 110001 (PRINT) → `mwrite` a single pulse in the 4th cycle, then `regprint` a single pulse 4 cycles later; `rwrite` never asserted.
- ROM[0] = 101010 (illegal) → `illegal`=1 and `halted`=1 after LATCH; no write strobe ever asserted. A subsequent `start` → `illegal`=0, `pc`=0, fetch resumes.
- PC_W=2, ROM = 4 NOPs → `imem_addr` sequence 0, 1, 2, 3, 0 with no stall.
- `rst_n`=0 asserted during WB of an ALU op → next cycle all outputs 0 and `pc`=START_PC; `start` pulsed while busy has no effect.
